// File: rtl/sobel_window_sequencer.sv
// sobel_window_sequencer
// Walks an IMG_W x IMG_H greyscale image in raster order. For every interior
// pixel it reads the 3x3 neighbourhood through the arbiter read port, forms
// the saturated Sobel magnitude |Gx|+|Gy| and writes one result pixel through
// the arbiter write port. A read and a write are never requested together.
//
// Optional build macro: SOBEL_THRESH_EN
//   defined   -> each written pixel is binarised: 255 if magnitude >= THRESH,
//                else 0
//   undefined -> the saturated magnitude is written and THRESH has no effect
module sobel_window_sequencer #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 8,
  parameter int THRESH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              busy,
  input  logic [7:0]        data_r,
  input  logic              write_done,
  output logic              start_read,
  output logic [ADDR_W-1:0] addr_r_mc,
  output logic              start_write,
  output logic [ADDR_W-1:0] addr_w_mc,
  output logic [7:0]        data_w,
  output logic              active,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

`ifdef SOBEL_THRESH_EN
  localparam bit THRESH_EN = 1'b1;
`else
  localparam bit THRESH_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] W_L    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(IMG_H - 2);
  localparam logic [11:0]       THR_L  = 12'(THRESH);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] r;
  logic [ADDR_W-1:0] c;
  logic [3:0]        k;
  logic [7:0]        p [0:8];

  logic [3:0]        win_off_k;
  logic [ADDR_W-1:0] row_sel;
  logic [ADDR_W-1:0] col_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  logic [9:0]        sx_pos;
  logic [9:0]        sx_neg;
  logic [9:0]        sy_pos;
  logic [9:0]        sy_neg;
  logic signed [10:0] gx;
  logic signed [10:0] gy;
  logic [11:0]       mag;
  logic [7:0]        mag_sat;
  logic [7:0]        pix_out;

  // Window index k -> {row offset, column offset}, each 0..2
  function automatic logic [3:0] win_off(input logic [3:0] kk);
    case (kk)
      4'd0:    return {2'd0, 2'd0};
      4'd1:    return {2'd0, 2'd1};
      4'd2:    return {2'd0, 2'd2};
      4'd3:    return {2'd1, 2'd0};
      4'd4:    return {2'd1, 2'd1};
      4'd5:    return {2'd1, 2'd2};
      4'd6:    return {2'd2, 2'd0};
      4'd7:    return {2'd2, 2'd1};
      default: return {2'd2, 2'd2};
    endcase
  endfunction

  // Absolute value of an 11-bit gradient; the largest magnitude is 1020
  function automatic logic [9:0] abs11(input logic signed [10:0] v);
    return 10'(v[10] ? -v : v);
  endfunction

  // Clamp the 12-bit magnitude to the 8-bit pixel range
  function automatic logic [7:0] sat8(input logic [11:0] m);
    return (m > 12'd255) ? 8'hFF : m[7:0];
  endfunction

  // Binarise a saturated magnitude against THRESH
  function automatic logic [7:0] binarise(input logic [7:0] m);
    return ({4'd0, m} >= THR_L) ? 8'hFF : 8'h00;
  endfunction

  // Read and write addresses for the current window position
  always_comb begin
    win_off_k = win_off(k);
    row_sel   = r - ONE + {{(ADDR_W-2){1'b0}}, win_off_k[3:2]};
    col_sel   = c - ONE + {{(ADDR_W-2){1'b0}}, win_off_k[1:0]};
    rd_addr   = row_sel * W_L + col_sel;
    wr_addr   = r * W_L + c;
  end

  // Sobel gradients from the captured window, saturated and optionally binarised
  always_comb begin
    sx_pos  = {2'b00, p[2]} + {1'b0, p[5], 1'b0} + {2'b00, p[8]};
    sx_neg  = {2'b00, p[0]} + {1'b0, p[3], 1'b0} + {2'b00, p[6]};
    sy_pos  = {2'b00, p[6]} + {1'b0, p[7], 1'b0} + {2'b00, p[8]};
    sy_neg  = {2'b00, p[0]} + {1'b0, p[1], 1'b0} + {2'b00, p[2]};
    gx      = $signed({1'b0, sx_pos}) - $signed({1'b0, sx_neg});
    gy      = $signed({1'b0, sy_pos}) - $signed({1'b0, sy_neg});
    mag     = {2'b00, abs11(gx)} + {2'b00, abs11(gy)};
    mag_sat = sat8(mag);
    pix_out = THRESH_EN ? binarise(mag_sat) : mag_sat;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and request outputs; requests depend on state only
  always_comb begin
    state_nxt   = state;
    start_read  = 1'b0;
    addr_r_mc   = '0;
    start_write = 1'b0;
    addr_w_mc   = '0;
    active      = (state != IDLE);
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = READ;
      end
      READ: begin
        start_read = 1'b1;
        addr_r_mc  = rd_addr;
        if (!busy && (k == 4'd8)) state_nxt = CALC;
      end
      CALC: begin
        state_nxt = WRITE;
      end
      WRITE: begin
        start_write = 1'b1;
        addr_w_mc   = wr_addr;
        if (write_done) begin
          if ((c < C_LAST) || (r < R_LAST)) state_nxt = READ;
          else                              state_nxt = DONE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window capture, result register and raster position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r      <= ONE;
      c      <= ONE;
      k      <= '0;
      data_w <= '0;
      for (int i = 0; i < 9; i++) p[i] <= '0;
    end else begin
      case (state)
        READ: begin
          if (!busy) begin
            p[k] <= data_r;
            k    <= (k == 4'd8) ? 4'd0 : k + 4'd1;
          end
        end
        CALC: begin
          data_w <= pix_out;
        end
        WRITE: begin
          if (write_done) begin
            if (c < C_LAST) begin
              c <= c + ONE;
            end else if (r < R_LAST) begin
              c <= ONE;
              r <= r + ONE;
            end else begin
              // Frame complete: park at the first interior pixel for the next frame
              c <= ONE;
              r <= ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
